// File: rtl/smpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smpc_pkg
// Description : Shared definitions for the SMPC peripheral port scanner:
//               port bit indices, select-line encodings, pad ID and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package smpc_pkg;

    // Port bit indices on the 7-bit peripheral port
    localparam int PB_TH = 6;
    localparam int PB_TR = 5;
    localparam int PB_TL = 4;

    // Port levels and direction: TH/TR/TL driven high, D3..D0 are inputs
    localparam logic [6:0] PO_RESET = 7'b1110000;
    localparam logic [6:0] PDDR_CFG = 7'b1110000;

    // {TH,TR} select encodings for each scan phase, and the idle level
    localparam logic [1:0] SEL_P0   = 2'b11;
    localparam logic [1:0] SEL_P1   = 2'b01;
    localparam logic [1:0] SEL_P2   = 2'b10;
    localparam logic [1:0] SEL_P3   = 2'b00;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    // ID reported by a Saturn standard digital pad in phase 0
    localparam logic [2:0] PAD_ID_STD = 3'b100;

    // Button word with nothing pressed (active-low)
    localparam logic [15:0] JOY_RELEASED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_t;

    // {TH,TR} levels for phase index p
    function automatic logic [1:0] phase_sel(input logic [1:0] p);
        logic [1:0] sel;
        case (p)
            2'd0:    sel = SEL_P0;
            2'd1:    sel = SEL_P1;
            2'd2:    sel = SEL_P2;
            default: sel = SEL_P3;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/smpc_pad_scan.sv
`default_nettype none
// ============================================================================
// Module      : smpc_pad_scan
// Description : Scans a Saturn standard digital pad through four TH/TR select
//               phases and publishes the assembled active-low button word on
//               JOY once per completed scan.
// Revision    : 1.0 - initial release
// ============================================================================
module smpc_pad_scan
    import smpc_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned SCAN_PERIOD = 4096
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        EN,
    input  logic        REQ,
    input  logic [6:0]  PI,
    output logic [6:0]  PO,
    output logic [6:0]  PDDR,
    output logic [15:0] JOY,
    output logic        PRESENT,
    output logic        VALID,
    output logic        BUSY
);

    localparam int SET_W = (SETTLE_CYC > 1)  ? $clog2(SETTLE_CYC)  : 1;
    localparam int PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [SET_W-1:0] C_SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [PER_W-1:0] C_PER_LOAD = PER_W'(SCAN_PERIOD - 1);

    scan_state_t        state_q,   state_d;
    logic [1:0]         phase_q,   phase_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic               pend_q,    pend_d;
    logic [2:0]         id_q,      id_d;
    logic [15:3]        shadow_q,  shadow_d;   // bits [2:0] are always 3'b111
    logic [1:0]         sel_q,     sel_d;      // {TH,TR} currently driven
    logic [15:0]        joy_q,     joy_d;
    logic               present_q, present_d;
    logic               valid_q,   valid_d;
    logic               busy_q,    busy_d;
    logic               pend_clr;

    // TH/TR/TL are output-only pins; only D3..D0 are read back
    logic unused_pi;
    assign unused_pi = ^PI[6:4];

    // Next-state logic: scan FSM, settle/period counters and request capture
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        set_cnt_d = set_cnt_q;
        per_cnt_d = per_cnt_q;
        id_d      = id_q;
        shadow_d  = shadow_q;
        sel_d     = sel_q;
        joy_d     = joy_q;
        present_d = present_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        pend_clr  = 1'b0;

        if (CE) begin
            valid_d = 1'b0;
            if (EN && (per_cnt_q != '0)) begin
                per_cnt_d = per_cnt_q - PER_W'(1);
            end

            if (!EN) begin
                // Abort: drop back to idle without publishing anything
                state_d = ST_IDLE;
                sel_d   = SEL_IDLE;
                busy_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if ((per_cnt_q == '0) || pend_q) begin
                            state_d   = ST_SEL;
                            phase_d   = 2'd0;
                            sel_d     = phase_sel(2'd0);
                            busy_d    = 1'b1;
                            per_cnt_d = C_PER_LOAD;
                            pend_clr  = 1'b1;
                        end
                    end
                    ST_SEL: begin
                        state_d   = ST_SETTLE;
                        set_cnt_d = C_SET_LOAD;
                    end
                    ST_SETTLE: begin
                        if (set_cnt_q == '0) begin
                            state_d = ST_SAMPLE;
                        end else begin
                            set_cnt_d = set_cnt_q - SET_W'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        case (phase_q)
                            2'd0: begin
                                id_d        = PI[2:0];
                                shadow_d[3] = PI[3];
                            end
                            2'd1:    shadow_d[15:12] = PI[3:0];
                            2'd2:    shadow_d[11:8]  = PI[3:0];
                            default: shadow_d[7:4]   = PI[3:0];
                        endcase
                        if (phase_q != 2'd3) begin
                            phase_d = phase_q + 2'd1;
                            sel_d   = phase_sel(phase_q + 2'd1);
                            state_d = ST_SEL;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (id_q == PAD_ID_STD) begin
                            joy_d     = {shadow_q, 3'b111};
                            present_d = 1'b1;
                        end else begin
                            joy_d     = JOY_RELEASED;
                            present_d = 1'b0;
                        end
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        sel_d   = SEL_IDLE;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        sel_d   = SEL_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end

        // REQ is sampled every clock; a request arriving on the start tick
        // itself is kept so it yields a follow-up scan
        pend_d = pend_clr ? REQ : (pend_q | REQ);
    end

    // State and registered outputs; async reset returns pins to idle levels
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            phase_q   <= 2'd0;
            set_cnt_q <= '0;
            per_cnt_q <= C_PER_LOAD;
            pend_q    <= 1'b0;
            id_q      <= 3'b000;
            shadow_q  <= '1;
            sel_q     <= SEL_IDLE;
            joy_q     <= JOY_RELEASED;
            present_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            set_cnt_q <= set_cnt_d;
            per_cnt_q <= per_cnt_d;
            pend_q    <= pend_d;
            id_q      <= id_d;
            shadow_q  <= shadow_d;
            sel_q     <= sel_d;
            joy_q     <= joy_d;
            present_q <= present_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Pin levels: TL parked high, D3..D0 undriven (direction is input)
    always_comb begin
        PO        = '0;
        PO[PB_TH] = sel_q[1];
        PO[PB_TR] = sel_q[0];
        PO[PB_TL] = 1'b1;
    end

    assign PDDR    = PDDR_CFG;
    assign JOY     = joy_q;
    assign PRESENT = present_q;
    assign VALID   = valid_q;
    assign BUSY    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_smpc_pad_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_smpc_pad_scan
// Description : Self-checking bench for smpc_pad_scan with a behavioural pad
//               model and a scoreboard of expected scan results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smpc_pad_scan;
    import smpc_pkg::*;

    localparam int SETTLE_CYC  = 16;
    localparam int SCAN_PERIOD = 4096;
    localparam int LAT         = 4 * (SETTLE_CYC + 2) + 1;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE    = 1'b1;
    logic        EN    = 1'b0;
    logic        REQ   = 1'b0;
    logic [6:0]  PI;
    logic [6:0]  PO;
    logic [6:0]  PDDR;
    logic [15:0] JOY;
    logic        PRESENT;
    logic        VALID;
    logic        BUSY;

    logic [2:0]  pad_id  = 3'b100;
    logic [15:0] pad_btn = 16'hFFFF;   // JOY bit layout, [2:0] ignored
    logic        ce_half = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] joy;
        logic        present;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic [2:0]  id;
        logic [15:0] btn;
        logic        ce_half;
        logic [15:0] exp_joy;
        logic        exp_present;
    } vec_t;
    vec_t vecs[8];

    always #5 CLK = ~CLK;

    smpc_pad_scan #(
        .SETTLE_CYC (SETTLE_CYC),
        .SCAN_PERIOD(SCAN_PERIOD)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CE     (CE),
        .EN     (EN),
        .REQ    (REQ),
        .PI     (PI),
        .PO     (PO),
        .PDDR   (PDDR),
        .JOY    (JOY),
        .PRESENT(PRESENT),
        .VALID  (VALID),
        .BUSY   (BUSY)
    );

    // Pad: returns the nibble selected by TH/TR
    always_comb begin
        PI[6:4] = 3'b111;
        case ({PO[PB_TH], PO[PB_TR]})
            2'b11:   PI[3:0] = {pad_btn[3], pad_id};
            2'b01:   PI[3:0] = pad_btn[15:12];
            2'b10:   PI[3:0] = pad_btn[11:8];
            default: PI[3:0] = pad_btn[7:4];
        endcase
    end

    // Clock enable: every cycle, or every other cycle when ce_half is set
    always @(negedge CLK) CE = ce_half ? ~CE : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every VALID rising edge pops one expected result
    logic valid_prev = 1'b0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            valid_prev = 1'b0;
        end else begin
            if (VALID && !valid_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("joy", JOY, mon_e.joy);
                    check("present", PRESENT, mon_e.present);
                    check("busy_at_valid", BUSY, 1'b0);
                end
            end
            valid_prev = VALID;
        end
    end

    task automatic pulse_req();
        @(negedge CLK); REQ = 1'b1;
        @(negedge CLK); REQ = 1'b0;
    endtask

    task automatic wait_busy(input int max);
        int n = 0;
        while (!BUSY && n < max) begin @(negedge CLK); n++; end
        check("busy_timeout", BUSY, 1'b1);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!VALID && n < max) begin @(negedge CLK); n++; end
        check("valid_timeout", VALID, 1'b1);
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (sb_q.size() != 0 && n < max) begin @(negedge CLK); n++; end
        check("drain_timeout", sb_q.size(), 0);
        sb_q.delete();
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   n;
        int   t;
        int   nseq;
        int   joy_changes;
        int   tph[4];
        logic seen;
        logic changed;
        logic [1:0]  cur_sel;
        logic [1:0]  prev_sel;
        logic [7:0]  seq;
        logic [15:0] joy0;

        vecs[0] = '{3'b100, 16'hEBE7, 1'b0, 16'hEBE7, 1'b1};
        vecs[1] = '{3'b111, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};  // pad absent
        vecs[2] = '{3'b100, 16'h0000, 1'b0, 16'h0007, 1'b1};  // all pressed
        vecs[3] = '{3'b100, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};  // half-rate CE
        vecs[4] = '{3'b101, 16'h0000, 1'b0, 16'hFFFF, 1'b0};  // foreign ID
        vecs[5] = '{3'b100, 16'h5A5F, 1'b0, 16'h5A5F, 1'b1};
        vecs[6] = '{3'b100, 16'hA5A7, 1'b1, 16'hA5A7, 1'b1};  // half-rate CE
        vecs[7] = '{3'b000, 16'hEBE7, 1'b0, 16'hFFFF, 1'b0};

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_po", PO, 7'b1110000);
        check("rst_pddr", PDDR, 7'b1110000);
        check("rst_joy", JOY, 16'hFFFF);
        check("rst_present", PRESENT, 1'b0);
        check("rst_valid", VALID, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        RST_N = 1'b1;
        EN    = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_busy", BUSY, 1'b0);
        check("idle_pddr", PDDR, 7'b1110000);

        // Basic scan and latency from scan start to VALID
        pad_id  = 3'b100;
        pad_btn = 16'hEBE7;
        sb_q.push_back('{16'hEBE7, 1'b1});
        pulse_req();
        wait_busy(10);
        wait_valid(200, n);
        check("latency", n, LAT);
        wait_drain(50);

        // Table-driven scans
        for (int i = 0; i < 8; i++) begin
            pad_id  = vecs[i].id;
            pad_btn = vecs[i].btn;
            ce_half = vecs[i].ce_half;
            sb_q.push_back('{vecs[i].exp_joy, vecs[i].exp_present});
            pulse_req();
            wait_drain(400);
            ce_half = 1'b0;
            repeat (3) @(negedge CLK);
        end

        // Requests during a scan merge into exactly one follow-up scan
        pad_id  = 3'b100;
        pad_btn = 16'hEBE7;
        sb_q.push_back('{16'hEBE7, 1'b1});
        sb_q.push_back('{16'hEBE7, 1'b1});
        pulse_req();
        wait_busy(10);
        repeat (10) @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            pulse_req();
            repeat (5) @(negedge CLK);
        end
        wait_valid(200, n);
        check("busy_at_done", BUSY, 1'b0);
        @(negedge CLK);
        check("rescan_start", BUSY, 1'b1);
        wait_drain(200);
        seen = 1'b0;
        repeat (150) begin
            @(negedge CLK);
            if (BUSY) seen = 1'b1;
        end
        check("no_third_scan", seen, 1'b0);

        // EN dropped during phase 2 settle: abort, keep JOY and pending request
        pad_btn = 16'h0000;
        pulse_req();
        wait_busy(10);
        n = 0;
        while ({PO[PB_TH], PO[PB_TR]} != 2'b10 && n < 100) begin @(negedge CLK); n++; end
        check("p2_reached", {PO[PB_TH], PO[PB_TR]}, 2'b10);
        repeat (4) @(negedge CLK);
        REQ = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        EN  = 1'b0;
        @(negedge CLK);
        check("abort_sel", {PO[PB_TH], PO[PB_TR]}, 2'b11);
        check("abort_busy", BUSY, 1'b0);
        check("abort_valid", VALID, 1'b0);
        check("abort_joy", JOY, 16'hEBE7);
        check("abort_present", PRESENT, 1'b1);
        seen = 1'b0;
        repeat (50) begin
            @(negedge CLK);
            if (VALID || BUSY) seen = 1'b1;
        end
        check("abort_quiet", seen, 1'b0);
        sb_q.push_back('{16'h0007, 1'b1});
        EN = 1'b1;
        wait_drain(200);

        // Buttons change mid-scan; select sequence and phase timing
        pad_btn = 16'h1237;
        sb_q.push_back('{16'h1237, 1'b1});
        pulse_req();
        wait_busy(10);
        prev_sel    = {PO[PB_TH], PO[PB_TR]};
        seq         = {prev_sel, 6'b0};
        nseq        = 1;
        tph[0]      = 0;
        tph[1]      = 0;
        tph[2]      = 0;
        tph[3]      = 0;
        t           = 0;
        changed     = 1'b0;
        joy_changes = 0;
        joy0        = JOY;
        while (t < 200) begin
            @(negedge CLK);
            t++;
            if (VALID) break;
            cur_sel = {PO[PB_TH], PO[PB_TR]};
            if (cur_sel != prev_sel) begin
                if (nseq < 4) begin
                    seq[7 - 2*nseq -: 2] = cur_sel;
                    tph[nseq] = t;
                end
                nseq++;
                prev_sel = cur_sel;
            end
            if (cur_sel == 2'b00 && !changed) begin
                pad_btn = 16'hF237;
                changed = 1'b1;
            end
            if (JOY !== joy0) joy_changes++;
        end
        check("sel_count", nseq, 4);
        check("sel_seq", seq, 8'b11_01_10_00);
        check("p1_start", tph[1], SETTLE_CYC + 2);
        check("p2_start", tph[2], 2 * (SETTLE_CYC + 2));
        check("p3_start", tph[3], 3 * (SETTLE_CYC + 2));
        check("scan_latency", t, LAT);
        check("joy_stable", joy_changes, 0);
        check("sel_idle", {PO[PB_TH], PO[PB_TR]}, 2'b11);
        wait_drain(50);

        // Automatic scans every SCAN_PERIOD ticks with no requests
        pad_btn = 16'hEBE7;
        sb_q.push_back('{16'hEBE7, 1'b1});
        sb_q.push_back('{16'hEBE7, 1'b1});
        wait_busy(SCAN_PERIOD + 100);
        n = 0;
        while (BUSY && n < SCAN_PERIOD + 100) begin @(negedge CLK); n++; end
        while (!BUSY && n < SCAN_PERIOD + 100) begin @(negedge CLK); n++; end
        check("auto_period", n, SCAN_PERIOD);
        wait_drain(200);

        // Async reset in the middle of a scan
        pad_btn = 16'h0000;
        pulse_req();
        wait_busy(10);
        repeat (30) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_po", PO, 7'b1110000);
        check("arst_joy", JOY, 16'hFFFF);
        check("arst_present", PRESENT, 1'b0);
        check("arst_busy", BUSY, 1'b0);
        check("arst_valid", VALID, 1'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
